// File: rtl/weight_streamer.sv
// weight_streamer: transmit side of the serial weight-load interface.
// Accepts packed weight words over a valid/ready stream and shifts them out
// LSB-first on k, with copy as the shift enable for the model's weight register.
// Optional feature: define WEIGHT_STREAMER_CRC_EN to run a CRC-16-CCITT over the
// shifted bits; without it crc is tied to zero.
module weight_streamer #(
   parameter int WEIGHTS_B = 12864,
   parameter int WORD_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              copy,
   output logic              k,
   output logic              busy,
   output logic              done,
   output logic [15:0]       crc
);

   localparam int NWORDS = (WEIGHTS_B + WORD_W - 1) / WORD_W;
   localparam int REM_W  = $clog2(WEIGHTS_B + 1);
   localparam int CNT_W  = $clog2(WORD_W + 1);
   localparam int WL_W   = $clog2(NWORDS + 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   state_t            state_q, state_d;
   logic [WORD_W-1:0] sreg_q, sreg_d;
   logic [CNT_W-1:0]  wbits_q, wbits_d;
   logic [REM_W-1:0]  rem_q, rem_d;
   logic [WL_W-1:0]   words_q, words_d;

   // Bits to shift from a freshly loaded word: a full word, or only the
   // remaining LSBs when this is a partial last word.
   function automatic logic [CNT_W-1:0] wordBits(input logic [REM_W-1:0] rem);
      if (32'(rem) >= 32'(WORD_W)) begin
         return CNT_W'(WORD_W);
      end else begin
         return CNT_W'(rem);
      end
   endfunction

   // Next-state logic: word capture in LOAD, bit shifting and zero-bubble
   // prefetch of the following word on the last bit of each word in SHIFT.
   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      wbits_d = wbits_q;
      rem_d   = rem_q;
      words_d = words_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD;
               rem_d   = REM_W'(WEIGHTS_B);
               words_d = WL_W'(NWORDS);
            end
         end
         LOAD: begin
            if (s_valid) begin
               sreg_d  = s_data;
               wbits_d = wordBits(rem_q);
               words_d = words_q - 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sreg_d  = sreg_q >> 1;
            wbits_d = wbits_q - 1'b1;
            rem_d   = rem_q - 1'b1;
            if (wbits_q == CNT_W'(1)) begin
               if (words_q == '0) begin
                  state_d = DONE;
               end else if (s_valid) begin
                  sreg_d  = s_data;
                  wbits_d = wordBits(rem_q - 1'b1);
                  words_d = words_q - 1'b1;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any load in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         wbits_q <= '0;
         rem_q   <= '0;
         words_q <= '0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         wbits_q <= wbits_d;
         rem_q   <= rem_d;
         words_q <= words_d;
      end
   end

   assign copy    = (state_q == SHIFT);
   assign k       = copy & sreg_q[0];
   assign s_ready = (state_q == LOAD) ||
                    ((state_q == SHIFT) && (wbits_q == CNT_W'(1)) && (words_q != '0));
   assign busy    = (state_q == LOAD) || (state_q == SHIFT);
   assign done    = (state_q == DONE);

`ifdef WEIGHT_STREAMER_CRC_EN
   logic [15:0] crc_q, crc_d;

   // CRC next value: seeded when a load starts, advanced once per shifted bit,
   // and held otherwise so the final value stays visible after done.
   always_comb begin
      crc_d = crc_q;
      if ((state_q == IDLE) && start) begin
         crc_d = 16'hFFFF;
      end else if (state_q == SHIFT) begin
         crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ sreg_q[0]) ? 16'h1021 : 16'h0000);
      end
   end

   // CRC register.
   always_ff @(posedge clk) begin
      if (rst) begin
         crc_q <= '0;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;
`else
   assign crc = 16'h0000;
`endif

endmodule

// File: tb/tb_weight_streamer.sv
// Testbench for weight_streamer: a 40-bit/16-bit instance for the directed and
// randomized load scenarios, a default-parameter instance with random data, and
// a 1-bit/16-bit instance for the single-bit CRC case.
`timescale 1ns/1ps
module tb_weight_streamer;

   localparam int A_BITS = 40;
   localparam int A_WORD = 16;
   localparam int A_NW   = 3;
   localparam int B_BITS = 12864;
   localparam int B_WORD = 32;
   localparam int B_NW   = 402;
   localparam int C_BITS = 1;
   localparam int C_WORD = 16;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors;
   int checks;

   logic              aRst, aStart, aValid, aReady, aCopy, aK, aBusy, aDone;
   logic [A_WORD-1:0] aData;
   logic [15:0]       aCrc;
   logic              bRst, bStart, bValid, bReady, bCopy, bK, bBusy, bDone;
   logic [B_WORD-1:0] bData;
   logic [15:0]       bCrc;
   logic              cRst, cStart, cValid, cReady, cCopy, cK, cBusy, cDone;
   logic [C_WORD-1:0] cData;
   logic [15:0]       cCrc;

   weight_streamer #(.WEIGHTS_B(A_BITS), .WORD_W(A_WORD)) dutA (
      .clk(clk), .rst(aRst), .start(aStart), .s_data(aData), .s_valid(aValid),
      .s_ready(aReady), .copy(aCopy), .k(aK), .busy(aBusy), .done(aDone), .crc(aCrc));

   weight_streamer dutB (
      .clk(clk), .rst(bRst), .start(bStart), .s_data(bData), .s_valid(bValid),
      .s_ready(bReady), .copy(bCopy), .k(bK), .busy(bBusy), .done(bDone), .crc(bCrc));

   weight_streamer #(.WEIGHTS_B(C_BITS), .WORD_W(C_WORD)) dutC (
      .clk(clk), .rst(cRst), .start(cStart), .s_data(cData), .s_valid(cValid),
      .s_ready(cReady), .copy(cCopy), .k(cK), .busy(cBusy), .done(cDone), .crc(cCrc));

   // Observations of the A instance for the most recent load.
   logic [A_WORD-1:0] aWords [A_NW];
   logic [A_BITS-1:0] aRecv;
   logic [15:0]       aCrcAtDone;
   int aCopies, aHs, aDones, aFirstCopy, aLastCopy, aDoneCyc;
   bit aAbortSeen;

   // Observations of the default-parameter instance.
   logic [B_WORD-1:0] bWords [B_NW];
   logic [B_BITS-1:0] bRecv;
   logic [B_BITS-1:0] bExp;
   logic [15:0]       bCrcAtDone;
   int bCopies, bHs, bDones, bFirstCopy, bLastCopy, bDoneCyc;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Reference CRC-16-CCITT step, one bit at a time.
   function automatic logic [15:0] crcStep(input logic [15:0] c, input logic b);
      return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
   endfunction

   // Drives one load into the A instance and records what comes out. Options:
   // a validity gap before word 1, random s_valid, extra start pulses after a
   // given bit and in the DONE cycle, and a reset after a given number of bits.
   task automatic applyStimulus(input int gapLen, input bit randValid, input int startAtBit,
                                input bit startInDone, input int abortAt);
      int idx;
      int gapCnt;
      int cyc;
      int abortPhase;
      bit hs;
      bit nextStart;
      bit abortNow;
      bit finished;
      idx = 0; gapCnt = 0; cyc = 0; abortPhase = 0; finished = 0;
      aCopies = 0; aHs = 0; aDones = 0; aFirstCopy = -1; aLastCopy = -1; aDoneCyc = -1;
      aRecv = '0; aCrcAtDone = '0; aAbortSeen = 0;
      @(posedge clk); #1;
      aStart = 1'b1;
      aData  = aWords[0];
      aValid = randValid ? ($urandom_range(0, 3) != 0) : 1'b1;
      while (!finished) begin
         @(negedge clk);
         if (abortPhase == 2) begin
            checkOutput("A_abort_ctrl", {aCopy, aBusy, aReady, aDone}, 4'b0000);
            checkOutput("A_abort_crc", aCrc, 16'h0000);
            aAbortSeen = 1;
            finished = 1;
         end else begin
            hs = aValid && aReady;
            nextStart = 0;
            abortNow = 0;
            if (aCopy) begin
               aRecv = {aK, aRecv[A_BITS-1:1]};
               if (aFirstCopy < 0) aFirstCopy = cyc;
               aLastCopy = cyc;
               aCopies++;
               if (aCopies == startAtBit) nextStart = 1;
               if (startInDone && aCopies == A_BITS) nextStart = 1;
               if (abortAt > 0 && aCopies == abortAt) abortNow = 1;
            end
            if (aDone) begin
               aDones++;
               if (aDoneCyc < 0) begin
                  aDoneCyc = cyc;
                  aCrcAtDone = aCrc;
               end
            end
            if (hs) aHs++;
            else if (idx == 1 && aReady && !aValid) gapCnt++;
            if (aDoneCyc >= 0 && cyc >= aDoneCyc + 6) finished = 1;
            if (cyc >= 400) finished = 1;
            if (!finished) begin
               @(posedge clk); #1;
               cyc++;
               if (hs) idx++;
               aData  = (idx < A_NW) ? aWords[idx] : 16'h0000;
               aStart = nextStart;
               if (abortPhase == 1) begin
                  aRst = 1'b0;
                  abortPhase = 2;
               end else if (abortNow) begin
                  aRst = 1'b1;
                  abortPhase = 1;
               end
               if (randValid) aValid = ($urandom_range(0, 3) != 0);
               else aValid = !(idx == 1 && gapCnt < gapLen);
            end
         end
      end
      aStart = 1'b0;
      aValid = 1'b0;
      aRst   = 1'b0;
   endtask

   // Compares a completed A load against the packed-word reference.
   task automatic checkLoadA(input string tag, input bit exactTiming, input int bubbles);
      logic [47:0] full;
      logic [15:0] crcExp;
      full = {aWords[2], aWords[1], aWords[0]};
      crcExp = 16'hFFFF;
      for (int i = 0; i < A_BITS; i++) crcExp = crcStep(crcExp, full[i]);
`ifndef WEIGHT_STREAMER_CRC_EN
      crcExp = 16'h0000;
`endif
      checkOutput({tag, "_copies"}, aCopies, A_BITS);
      checkOutput({tag, "_handshakes"}, aHs, A_NW);
      checkOutput({tag, "_donePulses"}, aDones, 1);
      checkOutput({tag, "_weights"}, aRecv, full[A_BITS-1:0]);
      checkOutput({tag, "_doneAfterLast"}, aDoneCyc, aLastCopy + 1);
      checkOutput({tag, "_crc"}, aCrcAtDone, crcExp);
      if (exactTiming) begin
         checkOutput({tag, "_firstCopy"}, aFirstCopy, 2);
         checkOutput({tag, "_bubbles"}, aLastCopy - aFirstCopy + 1 - aCopies, bubbles);
      end
   endtask

   // One continuous load of random words into the default-parameter instance.
   task automatic applyStimulusDefault();
      int idx;
      int cyc;
      bit hs;
      logic [15:0] crcExp;
      idx = 0; cyc = 0;
      bCopies = 0; bHs = 0; bDones = 0; bFirstCopy = -1; bLastCopy = -1; bDoneCyc = -1;
      bRecv = '0; bCrcAtDone = '0;
      for (int i = 0; i < B_NW; i++) begin
         bWords[i] = $urandom();
         bExp[i*B_WORD +: B_WORD] = bWords[i];
      end
      @(posedge clk); #1;
      bStart = 1'b1;
      bValid = 1'b1;
      bData  = bWords[0];
      while (cyc < 13200 && !(bDoneCyc >= 0 && cyc >= bDoneCyc + 3)) begin
         @(negedge clk);
         hs = bValid && bReady;
         if (bCopy) begin
            bRecv = {bK, bRecv[B_BITS-1:1]};
            if (bFirstCopy < 0) bFirstCopy = cyc;
            bLastCopy = cyc;
            bCopies++;
         end
         if (bDone) begin
            bDones++;
            if (bDoneCyc < 0) begin
               bDoneCyc = cyc;
               bCrcAtDone = bCrc;
            end
         end
         if (hs) bHs++;
         @(posedge clk); #1;
         cyc++;
         bStart = 1'b0;
         if (hs) idx++;
         bData = (idx < B_NW) ? bWords[idx] : '0;
      end
      bValid = 1'b0;
      crcExp = 16'hFFFF;
      for (int i = 0; i < B_BITS; i++) crcExp = crcStep(crcExp, bExp[i]);
`ifndef WEIGHT_STREAMER_CRC_EN
      crcExp = 16'h0000;
`endif
      checkOutput("B_copies", bCopies, B_BITS);
      checkOutput("B_span", bLastCopy - bFirstCopy + 1, B_BITS);
      checkOutput("B_firstCopy", bFirstCopy, 2);
      checkOutput("B_handshakes", bHs, B_NW);
      checkOutput("B_donePulses", bDones, 1);
      checkOutput("B_doneAfterLast", bDoneCyc, bLastCopy + 1);
      checkOutput("B_weights", (bRecv == bExp), 1'b1);
      checkOutput("B_crc", bCrcAtDone, crcExp);
   endtask

   // Single-bit load into the C instance; expCrc is the required crc at done.
   task automatic applyStimulusCrc(input string tag, input logic [15:0] w, input logic [15:0] expCrc);
      int cyc;
      int copies;
      int hsCount;
      int dones;
      logic bitSeen;
      logic [15:0] crcAtDone;
      bit hs;
      cyc = 0; copies = 0; hsCount = 0; dones = 0; bitSeen = 1'b0; crcAtDone = '0;
      @(posedge clk); #1;
      cStart = 1'b1;
      cValid = 1'b1;
      cData  = w;
      while (cyc < 12) begin
         @(negedge clk);
         hs = cValid && cReady;
         if (cCopy) begin
            copies++;
            bitSeen = cK;
         end
         if (cDone) begin
            dones++;
            crcAtDone = cCrc;
         end
         if (hs) hsCount++;
         @(posedge clk); #1;
         cyc++;
         cStart = 1'b0;
      end
      cValid = 1'b0;
      checkOutput({tag, "_copies"}, copies, C_BITS);
      checkOutput({tag, "_bit"}, bitSeen, w[0]);
      checkOutput({tag, "_handshakes"}, hsCount, 1);
      checkOutput({tag, "_donePulses"}, dones, 1);
      checkOutput({tag, "_crc"}, crcAtDone, expCrc);
   endtask

   initial begin
      logic [15:0] crcOne;
      logic [15:0] crcZero;
      errors = 0;
      checks = 0;
      aRst = 1'b1; aStart = 1'b0; aValid = 1'b0; aData = '0;
      bRst = 1'b1; bStart = 1'b0; bValid = 1'b0; bData = '0;
      cRst = 1'b1; cStart = 1'b0; cValid = 1'b0; cData = '0;
      repeat (3) @(posedge clk);
      #1;
      aRst = 1'b0; bRst = 1'b0; cRst = 1'b0;
      @(negedge clk);
      checkOutput("A_reset_ctrl", {aCopy, aK, aReady, aBusy, aDone}, 5'b00000);
      checkOutput("A_reset_crc", aCrc, 16'h0000);
      checkOutput("B_reset_ctrl", {bCopy, bK, bReady, bBusy, bDone}, 5'b00000);
      checkOutput("C_reset_ctrl", {cCopy, cK, cReady, cBusy, cDone}, 5'b00000);

      $display("[TB] continuous load");
      aWords[0] = 16'hA5C3; aWords[1] = 16'h1234; aWords[2] = 16'hFF5A;
      applyStimulus(0, 1'b0, -1, 1'b0, -1);
      checkLoadA("cont", 1'b1, 0);
      checkOutput("cont_vector", aRecv, 40'h5A1234A5C3);
      checkOutput("cont_first8", aRecv[7:0], 8'hC3);
      checkOutput("cont_last8", aRecv[39:32], 8'h5A);

      $display("[TB] back-pressure before word 1");
      applyStimulus(5, 1'b0, -1, 1'b0, -1);
      checkLoadA("gap", 1'b1, 5);
      checkOutput("gap_vector", aRecv, 40'h5A1234A5C3);

      $display("[TB] reset in the middle of a load");
      applyStimulus(0, 1'b0, -1, 1'b0, 20);
      checkOutput("abort_reached", aAbortSeen, 1'b1);
      checkOutput("abort_donePulses", aDones, 0);
      aWords[0] = 16'h0F0F; aWords[1] = 16'hC001; aWords[2] = 16'h7E81;
      applyStimulus(0, 1'b0, -1, 1'b0, -1);
      checkLoadA("afterAbort", 1'b1, 0);

      $display("[TB] start while busy and in DONE");
      applyStimulus(0, 1'b0, 10, 1'b1, -1);
      checkLoadA("ignoreStart", 1'b1, 0);
      checkOutput("ignoreStart_idle", {aBusy, aCopy, aReady}, 3'b000);

      $display("[TB] random words with random s_valid");
      for (int t = 0; t < 3; t++) begin
         for (int w = 0; w < A_NW; w++) aWords[w] = 16'($urandom());
         applyStimulus(0, 1'b1, -1, 1'b0, -1);
         checkLoadA("rand", 1'b0, 0);
      end

      $display("[TB] default parameters with random data");
      applyStimulusDefault();

      $display("[TB] single-bit load");
      crcZero = crcStep(16'hFFFF, 1'b0);
`ifdef WEIGHT_STREAMER_CRC_EN
      crcOne = 16'hFFFE;
`else
      crcOne  = 16'h0000;
      crcZero = 16'h0000;
`endif
      applyStimulusCrc("crcOne", 16'h0001, crcOne);
      applyStimulusCrc("crcZero", 16'hFFF0, crcZero);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
